// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin Wishbone arbiter.
// Holds the FSM state encoding and the default bus widths.
package wb_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TOUT  = 2'd2
   } arb_state_e;

   localparam int WB_NUM_M   = 2;
   localparam int WB_AW      = 32;
   localparam int WB_DW      = 32;
   localparam int WB_TIMEOUT = 255;
   localparam int WB_TW      = 16;

   // Width of an index into n items; never zero, so n=1 still yields a legal vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding bus.
interface wb_rr_arbiter_if
   import wb_rr_arbiter_pkg::*;
#(
   parameter int NUM_M = WB_NUM_M,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) ();

   logic [NUM_M-1:0]        m_cyc_i;
   logic [NUM_M-1:0]        m_stb_i;
   logic [NUM_M-1:0]        m_we_i;
   logic [NUM_M*DW/8-1:0]   m_sel_i;
   logic [NUM_M*AW-1:0]     m_adr_i;
   logic [NUM_M*DW-1:0]     m_dat_i;
   logic [DW-1:0]           m_dat_o;
   logic [NUM_M-1:0]        m_ack_o;
   logic [NUM_M-1:0]        m_err_o;

   logic                    s_cyc_o;
   logic                    s_stb_o;
   logic                    s_we_o;
   logic [DW/8-1:0]         s_sel_o;
   logic [AW-1:0]           s_adr_o;
   logic [DW-1:0]           s_dat_o;
   logic [DW-1:0]           s_dat_i;
   logic                    s_ack_i;
   logic                    s_err_i;

   logic [NUM_M-1:0]        gnt_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      input  s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output gnt_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  gnt_o
   );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
// Kept free of bus details so an interrupt controller can reuse it.
module rr_pick
   import wb_rr_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int LW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [LW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic          o_valid
);

   always_comb begin
      int v_idx;
      o_gnt   = '0;
      o_valid = 1'b0;
      v_idx   = 0;
      for (int i = 1; i <= N; i++) begin
         v_idx = (int'(i_last) + i) % N;
         if (!o_valid && i_req[v_idx[LW-1:0]]) begin
            o_gnt[v_idx[LW-1:0]] = 1'b1;
            o_valid              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 classic arbiter: NUM_M masters onto one slave port,
// grant held for the whole cyc burst, watchdog errors out accesses never acked.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no owner; pick next requester after r_last
//   ST_GRANT | r_gnt owns the slave; signals routed, watchdog running
//   ST_TOUT  | watchdog expired; slave cyc dropped, 1-cycle err to owner
module wb_rr_arbiter
   import wb_rr_arbiter_pkg::*;
#(
   parameter int NUM_M   = WB_NUM_M,
   parameter int AW      = WB_AW,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = WB_TIMEOUT,
   parameter int TW      = WB_TW
) (
   input  logic              clk_i,
   input  logic              rst_i,
   wb_rr_arbiter_if.slave    bus
);

   localparam int SW = DW / 8;
   localparam int LW = idx_w(NUM_M);

   arb_state_e        r_state;
   logic [NUM_M-1:0]  r_gnt;
   logic [LW-1:0]     r_last;
   logic [TW-1:0]     r_wd;

   logic [NUM_M-1:0]  w_win_oh;
   logic              w_win_valid;
   logic [LW-1:0]     w_win_idx;

   logic              w_cyc;
   logic              w_stb;
   logic              w_we;
   logic [SW-1:0]     w_sel;
   logic [AW-1:0]     w_adr;
   logic [DW-1:0]     w_dat;
   logic [NUM_M-1:0]  w_ack;
   logic [NUM_M-1:0]  w_err;

   rr_pick #(
      .N  (NUM_M),
      .LW (LW)
   ) u_pick (
      .i_req   (bus.m_cyc_i),
      .i_last  (r_last),
      .o_gnt   (w_win_oh),
      .o_valid (w_win_valid)
   );

   always_comb begin
      w_win_idx = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (w_win_oh[k]) w_win_idx = LW'(k);
      end
   end

   // Only the GRANT state drives the slave, so IDLE and TOUT present an idle bus.
   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_sel = '0;
      w_adr = '0;
      w_dat = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (r_state == ST_GRANT && r_gnt[k]) begin
            w_cyc = bus.m_cyc_i[k];
            w_stb = bus.m_stb_i[k] & bus.m_cyc_i[k];
            w_we  = bus.m_we_i[k];
            w_sel = bus.m_sel_i[k*SW +: SW];
            w_adr = bus.m_adr_i[k*AW +: AW];
            w_dat = bus.m_dat_i[k*DW +: DW];
         end
      end
   end

   always_comb begin
      w_ack = '0;
      w_err = '0;
      if (r_state == ST_GRANT) begin
         w_ack = r_gnt & {NUM_M{bus.s_ack_i}};
         w_err = r_gnt & {NUM_M{bus.s_err_i}};
      end else if (r_state == ST_TOUT) begin
         w_err = r_gnt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_last  <= LW'(NUM_M - 1);
         r_wd    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_wd <= '0;
               if (w_win_valid) begin
                  r_state <= ST_GRANT;
                  r_gnt   <= w_win_oh;
                  r_last  <= w_win_idx;
               end
            end
            ST_GRANT: begin
               if (!w_cyc) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_wd    <= '0;
               end else if (w_stb && !bus.s_ack_i && !bus.s_err_i) begin
                  // Expiry fires on the TIMEOUT-th unanswered strobe cycle; an ack that cycle wins.
                  if (r_wd == TW'(TIMEOUT - 1)) begin
                     r_state <= ST_TOUT;
                     r_wd    <= '0;
                  end else begin
                     r_wd <= r_wd + 1'b1;
                  end
               end else begin
                  r_wd <= '0;
               end
            end
            ST_TOUT: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_wd    <= '0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_wd    <= '0;
            end
         endcase
      end
   end

   assign bus.s_cyc_o = w_cyc;
   assign bus.s_stb_o = w_stb;
   assign bus.s_we_o  = w_we;
   assign bus.s_sel_o = w_sel;
   assign bus.s_adr_o = w_adr;
   assign bus.s_dat_o = w_dat;
   assign bus.m_ack_o = w_ack;
   assign bus.m_err_o = w_err;
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.gnt_o   = r_gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a 2-master instance (TIMEOUT=8) and a 4-master instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_wb_rr_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0004;
   localparam logic [31:0] A1 = 32'h2000_0008;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   wb_rr_arbiter_if #(.NUM_M(2), .AW(32), .DW(32)) bus_a ();
   wb_rr_arbiter_if #(.NUM_M(4), .AW(32), .DW(32)) bus_b ();

   wb_rr_arbiter #(.NUM_M(2), .AW(32), .DW(32), .TIMEOUT(8), .TW(16)) u_dut_a (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus_a)
   );

   wb_rr_arbiter #(.NUM_M(4), .AW(32), .DW(32), .TIMEOUT(8), .TW(16)) u_dut_b (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus_a.m_cyc_i = '0;
      bus_a.m_stb_i = '0;
      bus_a.m_we_i  = '0;
      bus_a.m_sel_i = '1;
      bus_a.m_adr_i = {A1, A0};
      bus_a.m_dat_i = {32'h1111_1111, 32'h0000_0000};
      bus_a.s_dat_i = '0;
      bus_a.s_ack_i = 1'b0;
      bus_a.s_err_i = 1'b0;
      bus_b.m_cyc_i = '0;
      bus_b.m_stb_i = '0;
      bus_b.m_we_i  = '0;
      bus_b.m_sel_i = '1;
      for (int k = 0; k < 4; k++) bus_b.m_adr_i[k*32 +: 32] = 32'h3000_0000 + 32'(k * 4);
      bus_b.m_dat_i = '0;
      bus_b.s_dat_i = '0;
      bus_b.s_ack_i = 1'b0;
      bus_b.s_err_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Called at the start of a GRANT cycle of master k on bus_a: one acked beat,
   // release, then k re-requests during the IDLE gap.
   task automatic serve(input logic k, input logic [1:0] exp, input string tag);
      bus_a.s_ack_i = 1'b1;
      bus_a.s_dat_i = 32'hA5A5_0000 | 32'(k);
      settle();
      chk({tag, "_gnt"}, 64'(bus_a.gnt_o), 64'(exp));
      chk({tag, "_adr"}, 64'(bus_a.s_adr_o), 64'(k ? A1 : A0));
      chk({tag, "_ack"}, 64'(bus_a.m_ack_o), 64'(exp));
      step();
      bus_a.m_cyc_i[k] = 1'b0;
      bus_a.m_stb_i[k] = 1'b0;
      bus_a.s_ack_i    = 1'b0;
      settle();
      chk({tag, "_hold_gnt"}, 64'(bus_a.gnt_o), 64'(exp));
      chk({tag, "_rel_cyc"}, 64'(bus_a.s_cyc_o), 64'(1'b0));
      step();
      bus_a.m_cyc_i[k] = 1'b1;
      bus_a.m_stb_i[k] = 1'b1;
      settle();
      chk({tag, "_idle_gnt"}, 64'(bus_a.gnt_o), 64'(2'b00));
      step();
   endtask

   initial begin
      logic [1:0] idx;
      logic [3:0] exp4;

      clear_inputs();
      #2;
      chk("rst_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      chk("rst_cyc", 64'(bus_a.s_cyc_o), 64'(1'b0));
      chk("rst_stb", 64'(bus_a.s_stb_o), 64'(1'b0));
      chk("rst_ack", 64'(bus_a.m_ack_o), 64'(2'b00));
      chk("rst_err", 64'(bus_a.m_err_o), 64'(2'b00));
      chk("rst_gnt_b", 64'(bus_b.gnt_o), 64'(4'b0000));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single master read
      bus_a.m_cyc_i[0] = 1'b1;
      bus_a.m_stb_i[0] = 1'b1;
      settle();
      chk("t1_req_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      chk("t1_req_cyc", 64'(bus_a.s_cyc_o), 64'(1'b0));
      step();
      settle();
      chk("t1_gnt", 64'(bus_a.gnt_o), 64'(2'b01));
      chk("t1_cyc", 64'(bus_a.s_cyc_o), 64'(1'b1));
      chk("t1_stb", 64'(bus_a.s_stb_o), 64'(1'b1));
      chk("t1_adr", 64'(bus_a.s_adr_o), 64'(A0));
      chk("t1_we", 64'(bus_a.s_we_o), 64'(1'b0));
      chk("t1_noack", 64'(bus_a.m_ack_o), 64'(2'b00));
      step();
      bus_a.s_ack_i = 1'b1;
      bus_a.s_dat_i = 32'hDEAD_BEEF;
      settle();
      chk("t1_ack", 64'(bus_a.m_ack_o), 64'(2'b01));
      chk("t1_dat", 64'(bus_a.m_dat_o), 64'(32'hDEAD_BEEF));
      chk("t1_err", 64'(bus_a.m_err_o), 64'(2'b00));
      step();
      bus_a.s_ack_i    = 1'b0;
      bus_a.m_cyc_i[0] = 1'b0;
      bus_a.m_stb_i[0] = 1'b0;
      settle();
      chk("t1_ack_off", 64'(bus_a.m_ack_o), 64'(2'b00));
      chk("t1_hold_gnt", 64'(bus_a.gnt_o), 64'(2'b01));
      chk("t1_rel_cyc", 64'(bus_a.s_cyc_o), 64'(1'b0));
      step();
      settle();
      chk("t1_idle_gnt", 64'(bus_a.gnt_o), 64'(2'b00));

      // contention from reset: order 0,1,0,1
      do_reset();
      bus_a.m_cyc_i = 2'b11;
      bus_a.m_stb_i = 2'b11;
      settle();
      chk("t2_req_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      step();
      serve(1'b0, 2'b01, "t2_rr0");
      serve(1'b1, 2'b10, "t2_rr1");
      serve(1'b0, 2'b01, "t2_rr2");
      serve(1'b1, 2'b10, "t2_rr3");

      // m1 holds a 4-beat burst while m0 waits
      do_reset();
      bus_a.m_cyc_i[1] = 1'b1;
      bus_a.m_stb_i[1] = 1'b1;
      bus_a.m_we_i[1]  = 1'b1;
      step();
      bus_a.m_cyc_i[0] = 1'b1;
      bus_a.m_stb_i[0] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         bus_a.s_ack_i = 1'b1;
         settle();
         chk("t3_burst_gnt", 64'(bus_a.gnt_o), 64'(2'b10));
         chk("t3_burst_ack", 64'(bus_a.m_ack_o), 64'(2'b10));
         chk("t3_burst_we", 64'(bus_a.s_we_o), 64'(1'b1));
         step();
      end
      bus_a.m_cyc_i[1] = 1'b0;
      bus_a.m_stb_i[1] = 1'b0;
      bus_a.s_ack_i    = 1'b0;
      settle();
      chk("t3_hold_gnt", 64'(bus_a.gnt_o), 64'(2'b10));
      step();
      settle();
      chk("t3_idle_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      step();
      settle();
      chk("t3_m0_gnt", 64'(bus_a.gnt_o), 64'(2'b01));
      chk("t3_m0_adr", 64'(bus_a.s_adr_o), 64'(A0));

      // watchdog expiry after 8 unanswered strobe cycles
      do_reset();
      bus_a.m_cyc_i[0] = 1'b1;
      bus_a.m_stb_i[0] = 1'b1;
      step();
      for (int c = 1; c <= 8; c++) begin
         settle();
         chk("t4_wait_stb", 64'(bus_a.s_stb_o), 64'(1'b1));
         chk("t4_wait_err", 64'(bus_a.m_err_o), 64'(2'b00));
         step();
      end
      bus_a.m_cyc_i[0] = 1'b0;
      bus_a.m_stb_i[0] = 1'b0;
      settle();
      chk("t4_tout_cyc", 64'(bus_a.s_cyc_o), 64'(1'b0));
      chk("t4_tout_stb", 64'(bus_a.s_stb_o), 64'(1'b0));
      chk("t4_tout_err", 64'(bus_a.m_err_o), 64'(2'b01));
      chk("t4_tout_ack", 64'(bus_a.m_ack_o), 64'(2'b00));
      step();
      settle();
      chk("t4_idle_err", 64'(bus_a.m_err_o), 64'(2'b00));
      chk("t4_idle_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      bus_a.m_cyc_i[0] = 1'b1;
      bus_a.m_stb_i[0] = 1'b1;
      step();
      for (int c = 1; c <= 7; c++) begin
         settle();
         chk("t4b_wait_stb", 64'(bus_a.s_stb_o), 64'(1'b1));
         chk("t4b_wait_err", 64'(bus_a.m_err_o), 64'(2'b00));
         step();
      end
      bus_a.s_ack_i = 1'b1;
      settle();
      chk("t4b_ack", 64'(bus_a.m_ack_o), 64'(2'b01));
      chk("t4b_noerr", 64'(bus_a.m_err_o), 64'(2'b00));
      step();
      bus_a.s_ack_i = 1'b0;
      settle();
      chk("t4b_after_err", 64'(bus_a.m_err_o), 64'(2'b00));
      chk("t4b_after_cyc", 64'(bus_a.s_cyc_o), 64'(1'b1));
      chk("t4b_after_gnt", 64'(bus_a.gnt_o), 64'(2'b01));

      // asynchronous reset in the middle of an m1 access
      do_reset();
      bus_a.m_cyc_i[1] = 1'b1;
      bus_a.m_stb_i[1] = 1'b1;
      step();
      settle();
      chk("t5_pre_gnt", 64'(bus_a.gnt_o), 64'(2'b10));
      chk("t5_pre_cyc", 64'(bus_a.s_cyc_o), 64'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_cyc", 64'(bus_a.s_cyc_o), 64'(1'b0));
      chk("t5_async_stb", 64'(bus_a.s_stb_o), 64'(1'b0));
      chk("t5_async_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_a.m_cyc_i = 2'b11;
      bus_a.m_stb_i = 2'b11;
      settle();
      chk("t5_req_gnt", 64'(bus_a.gnt_o), 64'(2'b00));
      step();
      settle();
      chk("t5_m0_gnt", 64'(bus_a.gnt_o), 64'(2'b01));

      // four masters requesting continuously, single-beat transfers
      do_reset();
      bus_b.m_cyc_i = 4'b1111;
      bus_b.m_stb_i = 4'b1111;
      settle();
      chk("t6_req_gnt", 64'(bus_b.gnt_o), 64'(4'b0000));
      step();
      for (int n = 0; n < 5; n++) begin
         idx  = 2'(n % 4);
         exp4 = 4'b0001 << idx;
         bus_b.s_ack_i = 1'b1;
         settle();
         chk("t6_gnt", 64'(bus_b.gnt_o), 64'(exp4));
         chk("t6_ack", 64'(bus_b.m_ack_o), 64'(exp4));
         chk("t6_adr", 64'(bus_b.s_adr_o), 64'(32'h3000_0000 + {28'd0, idx, 2'b00}));
         step();
         bus_b.m_cyc_i[idx] = 1'b0;
         bus_b.m_stb_i[idx] = 1'b0;
         bus_b.s_ack_i      = 1'b0;
         settle();
         chk("t6_hold_gnt", 64'(bus_b.gnt_o), 64'(exp4));
         step();
         bus_b.m_cyc_i[idx] = 1'b1;
         bus_b.m_stb_i[idx] = 1'b1;
         settle();
         chk("t6_idle_gnt", 64'(bus_b.gnt_o), 64'(4'b0000));
         step();
      end

      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
